// File: rtl/obi_fifo_bridge_pkg.sv
// Shared register map, status bit positions and address decode for the OBI mailbox bridge.
// Optional non-blocking writer mode with drop counters: FIFO_BRIDGE_NONBLOCK_EN.
package obi_fifo_bridge_pkg;

  localparam int MAX_CH = 16;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_THRESH = 2'd2;
  localparam logic [1:0] REG_DROP   = 2'd3;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 8;

  typedef struct packed {
    logic [3:0] ch;
    logic [1:0] rsel;
    logic       in_range;
  } addr_dec_t;

  // Channel field is masked to the configured channel-select width before the range check.
  function automatic addr_dec_t addr_decode(input logic [7:2] addr,
                                            input logic [3:0] ch_mask,
                                            input logic [4:0] num_ch);
    addr_dec_t d;
    d.ch       = addr[7:4] & ch_mask;
    d.rsel     = addr[3:2];
    d.in_range = ({1'b0, d.ch} < num_ch);
    return d;
  endfunction

endpackage

// File: rtl/obi_fifo_bridge_chan.sv
// One mailbox channel: FIFO storage, pointers, fill count, threshold and level interrupt.
// FIFO_BRIDGE_NONBLOCK_EN adds an 8-bit saturating drop counter.
module obi_fifo_bridge_chan
  import obi_fifo_bridge_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  FIFO_DEPTH = 8,
  localparam int CW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  thresh_we_i,
  input  logic [CW:0]           thresh_wdata_i,
`ifdef FIFO_BRIDGE_NONBLOCK_EN
  input  logic                  drop_inc_i,
  input  logic                  drop_clr_i,
  output logic [7:0]            drop_cnt_o,
`endif
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [CW:0]           count_o,
  output logic [CW:0]           thresh_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  irq_o
);

  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW:0] ONE_V   = (CW+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [CW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW:0]           count_q, count_d, thresh_q, thresh_d;
  logic                  irq_q, irq_d;

  always_comb begin
    wptr_d   = wptr_q + CW'(push_i);
    rptr_d   = rptr_q + CW'(pop_i);
    count_d  = count_q;
    thresh_d = thresh_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + ONE_V;
      2'b01:   count_d = count_q - ONE_V;
      default: ;
    endcase
    if (thresh_we_i) thresh_d = (thresh_wdata_i > DEPTH_V) ? DEPTH_V : thresh_wdata_i;
    irq_d = (thresh_q != '0) && (count_q >= thresh_q);
  end

  // NOTE: storage has no reset; the pointers and count alone define which words are valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= push_data_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

`ifdef FIFO_BRIDGE_NONBLOCK_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (drop_clr_i)                          drop_d = '0;
    else if (drop_inc_i && drop_q != 8'hFF)  drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_cnt_o = drop_q;
`endif

  assign pop_data_o = mem_q[rptr_q];
  assign count_o    = count_q;
  assign thresh_o   = thresh_q;
  assign full_o     = (count_q == DEPTH_V);
  assign empty_o    = (count_q == '0);
  assign irq_o      = irq_q;

endmodule

// File: rtl/obi_fifo_bridge_mc.sv
// Multi-channel OBI-to-OBI mailbox bridge: writer port pushes, reader port pops/status/threshold.
// FIFO_BRIDGE_NONBLOCK_EN makes writer DATA writes always granted, dropping (and counting) on full.
module obi_fifo_bridge_mc
  import obi_fifo_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_req_i,
  output logic                    wr_gnt_o,
  output logic                    wr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic                    wr_we_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic [DATA_WIDTH-1:0]   wr_wdata_i,
  output logic [DATA_WIDTH-1:0]   wr_rdata_o,
  input  logic                    rd_req_i,
  output logic                    rd_gnt_o,
  output logic                    rd_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  input  logic                    rd_we_i,
  input  logic [DATA_WIDTH/8-1:0] rd_be_i,
  input  logic [DATA_WIDTH-1:0]   rd_wdata_i,
  output logic [DATA_WIDTH-1:0]   rd_rdata_o,
  output logic [NUM_CH-1:0]       irq_o
);

  localparam int         CW       = $clog2(FIFO_DEPTH);
  localparam int         CH_W     = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH);
  localparam logic [3:0] CH_MASK  = 4'((1 << CH_W) - 1);
  localparam logic [4:0] NUM_CH_V = 5'(NUM_CH);

  addr_dec_t wr_dec, rd_dec;
  assign wr_dec = addr_decode(wr_addr_i[7:2], CH_MASK, NUM_CH_V);
  assign rd_dec = addr_decode(rd_addr_i[7:2], CH_MASK, NUM_CH_V);

  logic [DATA_WIDTH-1:0] pop_data [MAX_CH];
  logic [CW:0]           count    [MAX_CH];
  logic [CW:0]           thresh   [MAX_CH];
  logic [MAX_CH-1:0]     full, empty;

  // ---------------- writer port ----------------
  logic                  wr_is_data, wr_ready, wr_push;
  logic [DATA_WIDTH-1:0] wr_masked;

  assign wr_is_data = wr_dec.in_range && wr_we_i && (wr_dec.rsel == REG_DATA);
`ifdef FIFO_BRIDGE_NONBLOCK_EN
  logic wr_drop;
  assign wr_ready = 1'b1;
  assign wr_drop  = wr_gnt_o && wr_is_data && full[wr_dec.ch];
`else
  assign wr_ready = !(wr_is_data && full[wr_dec.ch]);
`endif
  assign wr_gnt_o = wr_req_i && !rst_i && wr_ready;
  assign wr_push  = wr_gnt_o && wr_is_data && !full[wr_dec.ch];

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    wr_masked = '0;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (wr_be_i[b]) wr_masked[8*b +: 8] = wr_wdata_i[8*b +: 8];
    end
  end

  // ---------------- reader port ----------------
  logic                  rd_is_pop, rd_pop, rd_thresh_we;
  logic [DATA_WIDTH-1:0] rd_rdata_d;

  assign rd_is_pop    = rd_dec.in_range && !rd_we_i && (rd_dec.rsel == REG_DATA);
  assign rd_gnt_o     = rd_req_i && !rst_i && !(rd_is_pop && empty[rd_dec.ch]);
  assign rd_pop       = rd_gnt_o && rd_is_pop;
  assign rd_thresh_we = rd_gnt_o && rd_dec.in_range && rd_we_i && (rd_dec.rsel == REG_THRESH);
`ifdef FIFO_BRIDGE_NONBLOCK_EN
  logic       rd_drop_clr;
  logic [7:0] drop_cnt [MAX_CH];
  assign rd_drop_clr = rd_gnt_o && rd_dec.in_range && rd_we_i && (rd_dec.rsel == REG_DROP);
`endif

  always_comb begin
    rd_rdata_d = '0;
    if (rd_dec.in_range && !rd_we_i) begin
      case (rd_dec.rsel)
        REG_DATA:   rd_rdata_d = pop_data[rd_dec.ch];
        REG_STATUS: begin
          rd_rdata_d[STATUS_COUNT_LSB +: CW+1] = count[rd_dec.ch];
          rd_rdata_d[STATUS_FULL_BIT]          = full[rd_dec.ch];
          rd_rdata_d[STATUS_EMPTY_BIT]         = empty[rd_dec.ch];
        end
        REG_THRESH: rd_rdata_d[CW:0] = thresh[rd_dec.ch];
        default: begin
`ifdef FIFO_BRIDGE_NONBLOCK_EN
          rd_rdata_d[7:0] = drop_cnt[rd_dec.ch];
`endif
        end
      endcase
    end
  end

  // ---------------- channels ----------------
  for (genvar c = 0; c < MAX_CH; c++) begin : g_ch
    if (c < NUM_CH) begin : g_on
      obi_fifo_bridge_chan #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_chan (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .push_i         (wr_push && (wr_dec.ch == 4'(c))),
        .push_data_i    (wr_masked),
        .pop_i          (rd_pop && (rd_dec.ch == 4'(c))),
        .thresh_we_i    (rd_thresh_we && (rd_dec.ch == 4'(c))),
        .thresh_wdata_i (rd_wdata_i[CW:0]),
`ifdef FIFO_BRIDGE_NONBLOCK_EN
        .drop_inc_i     (wr_drop && (wr_dec.ch == 4'(c))),
        .drop_clr_i     (rd_drop_clr && (rd_dec.ch == 4'(c))),
        .drop_cnt_o     (drop_cnt[c]),
`endif
        .pop_data_o     (pop_data[c]),
        .count_o        (count[c]),
        .thresh_o       (thresh[c]),
        .full_o         (full[c]),
        .empty_o        (empty[c]),
        .irq_o          (irq_o[c])
      );
    end else begin : g_off
      assign pop_data[c] = '0;
      assign count[c]    = '0;
      assign thresh[c]   = '0;
      assign full[c]     = 1'b0;
      assign empty[c]    = 1'b1;
`ifdef FIFO_BRIDGE_NONBLOCK_EN
      assign drop_cnt[c] = '0;
`endif
    end
  end

  // ---------------- responses ----------------
  logic                  wr_rvalid_q, rd_rvalid_q;
  logic [DATA_WIDTH-1:0] rd_rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_rvalid_q <= 1'b0;
      rd_rvalid_q <= 1'b0;
      rd_rdata_q  <= '0;
    end else begin
      wr_rvalid_q <= wr_gnt_o;
      rd_rvalid_q <= rd_gnt_o;
      rd_rdata_q  <= rd_gnt_o ? rd_rdata_d : '0;
    end
  end

  assign wr_rvalid_o = wr_rvalid_q;
  assign rd_rvalid_o = rd_rvalid_q;
  assign rd_rdata_o  = rd_rdata_q;
  assign wr_rdata_o  = '0;

  logic unused_ok;
  assign unused_ok = ^{wr_addr_i[ADDR_WIDTH-1:8], wr_addr_i[1:0], rd_addr_i[ADDR_WIDTH-1:8],
                       rd_addr_i[1:0], rd_be_i, rd_wdata_i[DATA_WIDTH-1:CW+1]};

endmodule
